nn_alu_pipe: RTL and testbench
==============================

# nn_alu_pipe

Registered, handshaked successor to the combinational datapath ALU, generalised in width and max-pool lane count, with a persistent MAC accumulator. It sits between the instruction decode stage and the layer writeback path. It accepts one operation per cycle over a valid/ready interface and returns a registered result one cycle later. It supports backpressure, signed multiply-accumulate, saturating accumulator readout and a sticky overflow flag.

## Interface
- BITWIDTH, 32, operand/result width; must be a multiple of MP_BITWIDTH
- MP_BITWIDTH, 8, max-pool lane width; LANES = BITWIDTH/MP_BITWIDTH lanes (4 by default = one 2x2 window)
- ACC_WIDTH, 64, accumulator width; must be ≥ 2*BITWIDTH
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low
- valid_i  in  1  operation present
- ready_o  out  1  operation accepted this cycle when valid_i & ready_o
- data1_i  in  BITWIDTH  operand 1 (weight / pool window / ReLU input)
- data2_i  in  BITWIDTH  operand 2 (activation)
- ALUCtrl_i  in  4  opcode
- valid_o  out  1  result present
- ready_i  in  1  downstream accepts result when valid_o & ready_i
- data_o  out  BITWIDTH  registered result
- Zero_o  out  1  registered (data1_i == data2_i) of the same operation
- acc_o  out  ACC_WIDTH  current accumulator value, raw
- ovf_o  out  1  sticky accumulator overflow

## Operation
- Opcodes: 0001 SUM d1+d2; 0010 SUB d1-d2; 0011 AND; 0100 OR; 0101 XOR; 0110 MUL, low BITWIDTH bits of signed d1*d2; 0111 RELU, d1 if signed d1>0 else 0; 1000 MAXPOOL; 1001 MAC; 1010 ACC_RD; 1011 ACC_CLR; all others, including 0000 and 1100-1111: pass d1.
- SUM/SUB wrap modulo 2^BITWIDTH.
- MAXPOOL: split d1 into LANES signed lanes, lane 0 = LSBs. Result = maximum lane, sign-extended to BITWIDTH. Ties are irrelevant (equal values). d2 is ignored.
- MAC: acc_next = acc + sext(d1*d2 signed, 2*BITWIDTH → ACC_WIDTH), with wrap-around. data_o = acc_next saturated to the signed BITWIDTH range [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- Signed overflow of the MAC addition sets ovf_o. ovf_o stays set until ACC_CLR or reset.
- ACC_RD: data_o = current acc, saturated as for MAC; acc is unchanged.
- ACC_CLR: acc ← 0, ovf_o ← 0, data_o = 0.
- Accumulator and ovf_o change only on an accepted transfer (valid_i & ready_o). Stalled or invalid cycles never touch them.
- Zero_o is computed for every opcode and registered alongside data_o.

## Timing
- Reset values: valid_o=0, data_o=0, Zero_o=0, acc_o=0, ovf_o=0. ready_o=1 after reset.
- ready_o = !valid_o | ready_i (combinational from ready_i; no input register).
- Latency: an operation accepted at edge N shows on data_o/valid_o after edge N; throughput is 1 per cycle with ready_i held high.
- Output register load: on accept, the register loads the new result and valid_o=1. If the result is taken (valid_o & ready_i) with no accept, valid_o←0 and data_o holds its last value.
- Stall (valid_o & !ready_i): data_o, Zero_o and valid_o are held stable. ready_o=0, so inputs are not consumed.
- Accept and drain in the same cycle: the register loads the new result and valid_o stays 1.
- acc_o updates on the same edge that loads the MAC/ACC_CLR result. A MAC issued the cycle after another MAC uses the updated acc (back-to-back accumulation has no bubble).
- Asynchronous reset mid-operation drops any in-flight result and clears acc and ovf immediately. The first accept is possible at the first rising edge after deassertion.

## Test plan
- Reset then back-to-back: SUM 5+7, SUB 3-5, XOR F0F0F0F0^0FF00FF0, ready_i=1 → data_o 12, FFFFFFFE, FF00FF00 on three consecutive cycles; Zero_o 0,0,0.
- MAXPOOL d1=80_7F_05_FF (lanes -1,5,127,-128) → data_o 0000007F; RELU d1=FFFFFFF6 → 0; MUL FFFFFFFE*3 → FFFFFFFA; SUB 9-9 → data_o 0, Zero_o 1.
- MAC: ACC_CLR, then MAC 3*4, then MAC -2*5 → data_o 12 then 2, acc_o 2. ACC_RD → data_o 2, acc_o unchanged.
- Saturation: ACC_CLR, MAC 7FFFFFFF*7FFFFFFF → data_o 7FFFFFFF, acc_o 3FFFFFFF00000001, ovf_o 0. Repeat until the ACC_WIDTH wrap → ovf_o 1, which persists through SUM ops until ACC_CLR.
- Backpressure: hold ready_i=0 with valid_i=1 and MAC 1*1 for 5 cycles → one result held stable, ready_o=0, acc increments exactly once. Release → the next MAC is accepted, acc=2.
- Async reset asserted between edges during a stalled MAC result → valid_o, data_o, acc_o, ovf_o go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/nn_alu_pipe.sv
// nn_alu_pipe: registered, valid/ready handshaked NN ALU with a persistent
// signed MAC accumulator, saturating readout and sticky overflow.
module nn_alu_pipe #(
  parameter int BITWIDTH    = 32,
  parameter int MP_BITWIDTH = 8,
  parameter int ACC_WIDTH   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [BITWIDTH-1:0]  data1_i,
  input  logic [BITWIDTH-1:0]  data2_i,
  input  logic [3:0]           ALUCtrl_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [BITWIDTH-1:0]  data_o,
  output logic                 Zero_o,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);

  localparam int LANES = BITWIDTH / MP_BITWIDTH;
  localparam int PW    = 2 * BITWIDTH;
  localparam int AM    = ACC_WIDTH - 1;

  localparam logic [3:0] OP_SUM  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_RELU = 4'b0111;
  localparam logic [3:0] OP_MAXP = 4'b1000;
  localparam logic [3:0] OP_MAC  = 4'b1001;
  localparam logic [3:0] OP_ARD  = 4'b1010;
  localparam logic [3:0] OP_ACLR = 4'b1011;

  logic                        r_valid;
  logic [BITWIDTH-1:0]         r_data;
  logic                        r_zero;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_ovf;

  logic                        w_accept;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_acc_sum;
  logic                        w_add_ovf;
  logic signed [MP_BITWIDTH-1:0] w_lane_max;
  logic [BITWIDTH-1:0]         w_res;
  logic signed [ACC_WIDTH-1:0] w_acc_nxt;
  logic                        w_ovf_nxt;

  // Clamp an accumulator value into the signed BITWIDTH range.
  function automatic logic [BITWIDTH-1:0] sat(
    input logic signed [ACC_WIDTH-1:0] v
  );
    logic [ACC_WIDTH-BITWIDTH:0] hi;
    hi = v[AM:BITWIDTH-1];
    if ((&hi) || !(|hi)) return v[BITWIDTH-1:0];
    else if (v[AM]) return {1'b1, {(BITWIDTH-1){1'b0}}};
    else return {1'b0, {(BITWIDTH-1){1'b1}}};
  endfunction

  assign ready_o  = !r_valid || ready_i;
  assign w_accept = valid_i && ready_o;

  assign w_prod     = PW'(signed'(data1_i)) * PW'(signed'(data2_i));
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_acc_sum  = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[AM] == w_prod_ext[AM]) &&
                      (w_acc_sum[AM] != r_acc[AM]);

  always_comb begin
    w_lane_max = data1_i[MP_BITWIDTH-1:0];
    for (int i = 1; i < LANES; i++) begin
      if (signed'(data1_i[i*MP_BITWIDTH +: MP_BITWIDTH]) > w_lane_max)
        w_lane_max = data1_i[i*MP_BITWIDTH +: MP_BITWIDTH];
    end
  end

  always_comb begin
    w_res     = data1_i;
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    unique case (ALUCtrl_i)
      OP_SUM:  w_res = data1_i + data2_i;
      OP_SUB:  w_res = data1_i - data2_i;
      OP_AND:  w_res = data1_i & data2_i;
      OP_OR:   w_res = data1_i | data2_i;
      OP_XOR:  w_res = data1_i ^ data2_i;
      OP_MUL:  w_res = w_prod[BITWIDTH-1:0];
      OP_RELU: begin
        if (data1_i[BITWIDTH-1] || !(|data1_i)) w_res = '0;
      end
      OP_MAXP: w_res = BITWIDTH'(w_lane_max);
      OP_MAC: begin
        w_acc_nxt = w_acc_sum;
        w_ovf_nxt = r_ovf || w_add_ovf;
        w_res     = sat(w_acc_sum);
      end
      OP_ARD:  w_res = sat(r_acc);
      OP_ACLR: begin
        w_acc_nxt = '0;
        w_ovf_nxt = 1'b0;
        w_res     = '0;
      end
      default: w_res = data1_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_res;
      r_zero  <= (data1_i == data2_i);
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign Zero_o  = r_zero;
  assign acc_o   = r_acc;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_nn_alu_pipe.sv
// Scoreboard bench for nn_alu_pipe: directed scenarios plus random traffic
// with random backpressure, checked against an arithmetic reference model.
module tb_nn_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [3:0]  ALUCtrl_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] data_o;
  logic        Zero_o;
  logic [63:0] acc_o;
  logic        ovf_o;

  nn_alu_pipe dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ALUCtrl_i (ALUCtrl_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o),
    .acc_o     (acc_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic [63:0] acc;
    logic        ovf;
  } exp_t;

  exp_t   q[$];
  longint macc = 0;
  bit     movf = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;
  bit     rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
    return v[31:0];
  endfunction

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint p;
    logic signed [127:0] exact;
    int best;
    byte ln;
    p = longint'(signed'(a)) * longint'(signed'(b));
    e.zero = (a == b);
    e.data = a;
    case (op)
      4'd1: e.data = a + b;
      4'd2: e.data = a - b;
      4'd3: e.data = a & b;
      4'd4: e.data = a | b;
      4'd5: e.data = a ^ b;
      4'd6: e.data = p[31:0];
      4'd7: e.data = ($signed(a) > 32'sd0) ? a : 32'h0;
      4'd8: begin
        best = -128;
        for (int i = 0; i < 4; i++) begin
          ln = a[8*i +: 8];
          if (int'(ln) > best) best = ln;
        end
        e.data = best;
      end
      4'd9: begin
        exact = 128'(macc) + 128'(p);
        if (exact > 128'sd9223372036854775807 ||
            exact < -128'sd9223372036854775808) movf = 1'b1;
        macc = macc + p;
        e.data = sat(macc);
      end
      4'd10: e.data = sat(macc);
      4'd11: begin
        macc = 0;
        movf = 1'b0;
        e.data = 32'h0;
      end
      default: e.data = a;
    endcase
    e.acc = macc;
    e.ovf = movf;
    return e;
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) begin
      v = $urandom_range(0, 40);
      v = v - 32'd20;
    end else begin
      v = $urandom;
    end
    return v;
  endfunction

  task automatic upd_ready();
    if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (ready_o) break;
      n++;
      if (n > 200) begin
        chk("accept timeout", 64'(ready_o), 64'(1'b1));
        valid_i = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      upd_ready();
    end
    q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    upd_ready();
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      upd_ready();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n_i && valid_o && ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected result", 64'(valid_o), 64'(1'b0));
      end else begin
        e = q.pop_front();
        chk("data_o", 64'(data_o), 64'(e.data));
        chk("Zero_o", 64'(Zero_o), 64'(e.zero));
        chk("acc_o", acc_o, e.acc);
        chk("ovf_o", 64'(ovf_o), 64'(e.ovf));
      end
    end
  end

  initial begin
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) @(posedge clk);
    #1;
    chk("rst valid_o", 64'(valid_o), 64'(1'b0));
    chk("rst data_o", 64'(data_o), 64'h0);
    chk("rst Zero_o", 64'(Zero_o), 64'(1'b0));
    chk("rst acc_o", acc_o, 64'h0);
    chk("rst ovf_o", 64'(ovf_o), 64'(1'b0));
    chk("rst ready_o", 64'(ready_o), 64'(1'b1));
    rst_n_i = 1'b1;

    issue(4'd1, 32'd5, 32'd7);
    chk("sum", 64'(data_o), 64'd12);
    issue(4'd2, 32'd3, 32'd5);
    chk("sub", 64'(data_o), 64'hFFFFFFFE);
    issue(4'd5, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("xor", 64'(data_o), 64'hFF00FF00);

    issue(4'd8, 32'h807F05FF, 32'h12345678);
    chk("maxpool", 64'(data_o), 64'h7F);
    issue(4'd7, 32'hFFFFFFF6, 32'h0);
    chk("relu neg", 64'(data_o), 64'h0);
    issue(4'd6, 32'hFFFFFFFE, 32'd3);
    chk("mul", 64'(data_o), 64'hFFFFFFFA);
    issue(4'd2, 32'd9, 32'd9);
    chk("sub zero", 64'(Zero_o), 64'(1'b1));

    issue(4'd11, 32'h0, 32'h0);
    issue(4'd9, 32'd3, 32'd4);
    chk("mac1", 64'(data_o), 64'd12);
    issue(4'd9, 32'hFFFFFFFE, 32'd5);
    chk("mac2", 64'(data_o), 64'd2);
    chk("mac2 acc", acc_o, 64'd2);
    issue(4'd10, 32'h0, 32'h0);
    chk("acc_rd", 64'(data_o), 64'd2);
    chk("acc_rd acc", acc_o, 64'd2);

    issue(4'd11, 32'h0, 32'h0);
    issue(4'd9, 32'h7FFFFFFF, 32'h7FFFFFFF);
    chk("sat data", 64'(data_o), 64'h7FFFFFFF);
    chk("sat acc", acc_o, 64'h3FFFFFFF00000001);
    chk("sat ovf", 64'(ovf_o), 64'(1'b0));
    repeat (2) issue(4'd9, 32'h7FFFFFFF, 32'h7FFFFFFF);
    chk("wrap ovf", 64'(ovf_o), 64'(1'b1));
    repeat (3) issue(4'd1, 32'd1, 32'd2);
    chk("ovf sticky", 64'(ovf_o), 64'(1'b1));
    issue(4'd11, 32'h0, 32'h0);
    chk("ovf clr", 64'(ovf_o), 64'(1'b0));

    idle(2);
    ready_i = 1'b0;
    issue(4'd9, 32'd1, 32'd1);
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall ready_o", 64'(ready_o), 64'(1'b0));
      chk("stall valid_o", 64'(valid_o), 64'(1'b1));
      chk("stall data_o", 64'(data_o), 64'd1);
      chk("stall acc_o", acc_o, 64'd1);
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    issue(4'd9, 32'd1, 32'd1);
    chk("release acc", acc_o, 64'd2);
    idle(2);

    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a = rnd_val();
      b = ($urandom_range(0, 7) == 0) ? a : rnd_val();
      issue(op, a, b);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    ready_i = 1'b1;
    idle(4);

    issue(4'd11, 32'h0, 32'h0);
    repeat (3) issue(4'd9, 32'h7FFFFFFF, 32'h7FFFFFFF);
    idle(2);
    ready_i = 1'b0;
    issue(4'd9, 32'd1, 32'd1);
    chk("pre-rst valid", 64'(valid_o), 64'(1'b1));
    chk("pre-rst ovf", 64'(ovf_o), 64'(1'b1));
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst valid_o", 64'(valid_o), 64'(1'b0));
    chk("arst data_o", 64'(data_o), 64'h0);
    chk("arst acc_o", acc_o, 64'h0);
    chk("arst ovf_o", 64'(ovf_o), 64'(1'b0));
    q.delete();
    macc = 0;
    movf = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    rst_n_i = 1'b1;
    @(posedge clk);
    #1;
    issue(4'd1, 32'd1, 32'd2);
    chk("post-rst sum", 64'(data_o), 64'd3);
    idle(3);
    chk("scoreboard drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
